// File: rtl/rvc_asap_fetch_if.sv
// rtl/rvc_asap_fetch_if.sv - I_MEM request/response, decode handshake and status bundle of the fetch unit
interface rvc_asap_fetch_if;
  logic        IMemReqValid;
  logic [31:0] IMemReqAddr;
  logic        IMemReqReady;
  logic        IMemRspValid;
  logic [31:0] IMemRspData;
  logic        RedirectValid;
  logic [31:0] RedirectPc;
  logic        InstValid;
  logic [31:0] InstData;
  logic [31:0] InstPc;
  logic        InstReady;
  logic        MisalignErr;

  modport master (
    output IMemReqValid, IMemReqAddr, InstValid, InstData, InstPc, MisalignErr,
    input  IMemReqReady, IMemRspValid, IMemRspData, RedirectValid, RedirectPc, InstReady
  );

  modport slave (
    input  IMemReqValid, IMemReqAddr, InstValid, InstData, InstPc, MisalignErr,
    output IMemReqReady, IMemRspValid, IMemRspData, RedirectValid, RedirectPc, InstReady
  );
endinterface

// File: rtl/rvc_asap_fetch.sv
// rtl/rvc_asap_fetch.sv - fetch PC, 1-cycle synchronous I_MEM reads, prefetch FIFO and redirect flush
module rvc_asap_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic             Clock,
  input  logic             Rst,
  rvc_asap_fetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          in_flight_q, in_flight_d;
  logic          misalign_q, misalign_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];

  logic          inst_valid, pop, push, req_valid, accept;
  logic [CW:0]   occupancy;

  always_comb begin
    inst_valid = !Rst && !bus.RedirectValid && (count_q != '0);
    pop        = inst_valid && bus.InstReady;
    // Credit counts the in-flight word so its response always has a slot.
    occupancy  = {1'b0, count_q} + (CW+1)'(in_flight_q) - (CW+1)'(pop);
    req_valid  = !Rst && !bus.RedirectValid && (occupancy < (CW+1)'(DEPTH));
    accept     = req_valid && bus.IMemReqReady;
    push       = !Rst && !bus.RedirectValid && bus.IMemRspValid && in_flight_q;

    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    in_flight_d = in_flight_q;
    misalign_d  = misalign_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    if (bus.RedirectValid) begin
      fetch_pc_d  = {bus.RedirectPc[31:2], 2'b00};
      in_flight_d = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      if (bus.RedirectPc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else begin
      if (accept) begin
        fetch_pc_d  = fetch_pc_q + 32'd4;
        req_pc_d    = fetch_pc_q;
        in_flight_d = 1'b1;
      end else if (bus.IMemRspValid) begin
        in_flight_d = 1'b0;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge Clock) begin
    if (Rst) begin
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= '0;
      in_flight_q <= 1'b0;
      misalign_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      in_flight_q <= in_flight_d;
      misalign_q  <= misalign_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge Clock) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= req_pc_q;
      data_mem_q[wr_ptr_q] <= bus.IMemRspData;
    end
  end

  assign bus.IMemReqValid = req_valid;
  assign bus.IMemReqAddr  = fetch_pc_q;
  assign bus.InstValid    = inst_valid;
  assign bus.InstData     = inst_valid ? data_mem_q[rd_ptr_q] : 32'h0;
  assign bus.InstPc       = inst_valid ? pc_mem_q[rd_ptr_q] : 32'h0;
  assign bus.MisalignErr  = misalign_q;
endmodule

// File: tb/tb_rvc_asap_fetch.sv
// tb/tb_rvc_asap_fetch.sv - randomized and directed checks of rvc_asap_fetch against a timestamped-queue model
module tb_rvc_asap_fetch;
  localparam logic [31:0] K       = 32'hA5A5_0000;
  localparam int          DEPTH   = 2;
  localparam logic [31:0] B_RESET = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rvc_asap_fetch_if ifa ();
  rvc_asap_fetch_if ifb ();

  rvc_asap_fetch #(.RESET_PC(32'h0), .DEPTH(DEPTH)) u_dut_a (.Clock(clk), .Rst(rst), .bus(ifa.master));
  rvc_asap_fetch #(.RESET_PC(B_RESET), .DEPTH(DEPTH)) u_dut_b (.Clock(clk), .Rst(rst), .bus(ifb.master));

  // Every word owed to decode, stamped with the first cycle it may be presented.
  typedef struct {
    logic [31:0] pc;
    int          rdy;
  } item_t;

  item_t       mq[$];
  logic [31:0] m_pc;
  bit          m_err;
  int          now;
  bit          primed;
  int          rel;
  bit          fv_pending;
  bit          pend_a, pend_b;
  logic [31:0] pend_a_addr, pend_b_addr;
  int          b_pops;
  logic [31:0] b_exp [3];
  int          n_checks;
  int          n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, now);
    end
  endtask

  task automatic monitor();
    bit exp_iv, exp_pop, exp_req, inflight;
    if (rst) begin
      check_eq("rst_req_valid", ifa.IMemReqValid, 0);
      check_eq("rst_inst_valid", ifa.InstValid, 0);
      check_eq("rst_b_inst_valid", ifb.InstValid, 0);
      if (primed) check_eq("rst_misalign", ifa.MisalignErr, m_err);
      mq.delete();
      m_pc       = 32'h0;
      m_err      = 1'b0;
      primed     = 1'b1;
      rel        = -1;
      fv_pending = 1'b1;
      b_pops     = 0;
      pend_a     = 1'b0;
      pend_b     = 1'b0;
    end else begin
      rel++;
      inflight = (mq.size() > 0) && (mq[mq.size()-1].rdy == now + 1);
      exp_iv   = !ifa.RedirectValid && (mq.size() > 0) && (mq[0].rdy <= now);
      check_eq("inst_valid", ifa.InstValid, exp_iv);
      if (exp_iv && ifa.InstValid) begin
        check_eq("inst_pc", ifa.InstPc, mq[0].pc);
        check_eq("inst_data", ifa.InstData, mq[0].pc ^ K);
      end
      if (fv_pending && ifa.InstValid) begin
        check_eq("first_valid_cycle", rel, 2);
        fv_pending = 1'b0;
      end
      exp_pop = exp_iv && ifa.InstReady;
      exp_req = !ifa.RedirectValid && ((mq.size() - int'(exp_pop)) < DEPTH);
      check_eq("req_valid", ifa.IMemReqValid, exp_req);
      check_eq("req_addr", ifa.IMemReqAddr, m_pc);
      check_eq("misalign", ifa.MisalignErr, m_err);
      check_eq("rsp_proto", ifa.IMemRspValid && !inflight, 0);

      pend_a      = ifa.IMemReqValid && ifa.IMemReqReady;
      pend_a_addr = ifa.IMemReqAddr;
      if (ifa.RedirectValid) begin
        mq.delete();
        m_pc  = {ifa.RedirectPc[31:2], 2'b00};
        m_err = m_err || (ifa.RedirectPc[1:0] != 2'b00);
      end else begin
        if (exp_pop) void'(mq.pop_front());
        if (exp_req && ifa.IMemReqReady) begin
          mq.push_back('{pc: m_pc, rdy: now + 2});
          m_pc = m_pc + 32'd4;
        end
      end

      if (ifb.InstValid && b_pops < 3) begin
        check_eq("wrap_pc", ifb.InstPc, b_exp[b_pops]);
        check_eq("wrap_data", ifb.InstData, b_exp[b_pops] ^ K);
        b_pops++;
      end
      pend_b      = ifb.IMemReqValid;
      pend_b_addr = ifb.IMemReqAddr;
    end
    now++;
  endtask

  task automatic step(input bit r, input bit rv, input logic [31:0] rpc, input bit mrdy, input bit irdy);
    @(posedge clk);
    #1;
    rst               = r;
    ifa.RedirectValid = rv;
    ifa.RedirectPc    = rpc;
    ifa.IMemReqReady  = mrdy;
    ifa.InstReady     = irdy;
    ifa.IMemRspValid  = pend_a;
    ifa.IMemRspData   = pend_a ? (pend_a_addr ^ K) : $urandom;
    ifb.RedirectValid = 1'b0;
    ifb.RedirectPc    = 32'h0;
    ifb.IMemReqReady  = 1'b1;
    ifb.InstReady     = 1'b1;
    ifb.IMemRspValid  = pend_b;
    ifb.IMemRspData   = pend_b ? (pend_b_addr ^ K) : $urandom;
    @(negedge clk);
    monitor();
  endtask

  initial begin
    logic [31:0] rpc;
    n_checks = 0;
    n_fail   = 0;
    now      = 0;
    primed   = 1'b0;
    pend_a   = 1'b0;
    pend_b   = 1'b0;
    b_exp[0] = 32'hFFFF_FFF8;
    b_exp[1] = 32'hFFFF_FFFC;
    b_exp[2] = 32'h0000_0000;
    ifa.RedirectValid = 1'b0; ifa.RedirectPc = 32'h0; ifa.IMemReqReady = 1'b1;
    ifa.InstReady = 1'b1; ifa.IMemRspValid = 1'b0; ifa.IMemRspData = 32'h0;
    ifb.RedirectValid = 1'b0; ifb.RedirectPc = 32'h0; ifb.IMemReqReady = 1'b1;
    ifb.InstReady = 1'b1; ifb.IMemRspValid = 1'b0; ifb.IMemRspData = 32'h0;

    repeat (3) step(1, 0, 0, 1, 1);
    check_eq("reset_addr", ifa.IMemReqAddr, 32'h0);

    // streaming, then decode backpressure
    repeat (12) step(0, 0, 0, 1, 1);
    repeat (6) step(0, 0, 0, 1, 0);
    check_eq("bp_full_no_req", ifa.IMemReqValid, 0);
    repeat (8) step(0, 0, 0, 1, 1);

    // memory stall at 0x10 from a fresh start
    step(1, 0, 0, 1, 1);
    repeat (4) step(0, 0, 0, 1, 1);
    repeat (3) step(0, 0, 0, 0, 1);
    check_eq("stall_addr_hold", ifa.IMemReqAddr, 32'h10);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    check_eq("stall_addr_next", ifa.IMemReqAddr, 32'h14);
    repeat (6) step(0, 0, 0, 1, 1);

    // redirect with a loaded FIFO
    repeat (3) step(0, 0, 0, 1, 0);
    step(0, 1, 32'h100, 1, 0);
    check_eq("redir_n_valid", ifa.InstValid, 0);
    step(0, 0, 0, 1, 1);
    check_eq("redir_n1_req", ifa.IMemReqValid, 1);
    check_eq("redir_n1_addr", ifa.IMemReqAddr, 32'h100);
    step(0, 0, 0, 1, 1);
    check_eq("redir_n2_valid", ifa.InstValid, 0);
    step(0, 0, 0, 1, 1);
    check_eq("redir_n3_valid", ifa.InstValid, 1);
    check_eq("redir_n3_pc", ifa.InstPc, 32'h100);

    // misaligned redirect
    step(0, 1, 32'h102, 1, 1);
    step(0, 0, 0, 1, 1);
    check_eq("misalign_addr", ifa.IMemReqAddr, 32'h100);
    repeat (5) step(0, 0, 0, 1, 1);
    check_eq("misalign_sticky", ifa.MisalignErr, 1);

    // randomized traffic, including redirects near the top of the address space
    for (int i = 0; i < 400; i++) begin
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      step(0, $urandom_range(0, 19) == 0, rpc, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end

    // reset in the middle of streaming
    repeat (4) step(0, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    repeat (8) step(0, 0, 0, 1, 1);
    check_eq("post_reset_misalign", ifa.MisalignErr, 0);
    check_eq("post_reset_wrap_seen", b_pops, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
